// File: rtl/dmem_line_adapter_if.sv
// Bus bundle between the LSQ dmem port, the line adapter and the banked memory.
// The adapter takes the slave view; the LSQ/memory side takes the master view.
interface dmem_line_adapter_if #(
  parameter int unsigned BEAT_WIDTH = 64
);
  logic [31:0]           dmem_addr;
  logic                  dmem_rmask;
  logic [3:0]            dmem_wmask;
  logic [31:0]           dmem_wdata;
  logic [31:0]           dmem_rdata;
  logic                  dmem_resp;
  logic [31:0]           bmem_addr;
  logic                  bmem_read;
  logic                  bmem_write;
  logic [BEAT_WIDTH-1:0] bmem_wdata;
  logic                  bmem_ready;
  logic [BEAT_WIDTH-1:0] bmem_rdata;
  logic                  bmem_rvalid;

  modport slave (
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, bmem_ready, bmem_rdata, bmem_rvalid,
    output dmem_rdata, dmem_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata
  );

  modport master (
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, bmem_ready, bmem_rdata, bmem_rvalid,
    input  dmem_rdata, dmem_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata
  );
endinterface

// File: rtl/dmem_line_adapter.sv
// Converts held LSQ word requests into line bursts through a single write-through
// line buffer; read hits answer in one cycle, everything else goes through the burst FSM.
module dmem_line_adapter #(
  parameter int unsigned BEAT_WIDTH = 64,
  parameter int unsigned LINE_BEATS = 4
) (
  input logic                clk,
  input logic                rst,
  dmem_line_adapter_if.slave bus
);
  localparam int unsigned LineBits = BEAT_WIDTH * LINE_BEATS;
  localparam int unsigned OffBits  = $clog2(LineBits / 8);
  localparam int unsigned TagBits  = 32 - OffBits;
  localparam int unsigned CntW     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

  typedef enum logic [2:0] {StIdle, StFillReq, StFillWait, StWb, StResp} state_e;

  state_e                state_q, state_d;
  logic [LineBits-1:0]   line_q, line_d;
  logic [TagBits-1:0]    tag_q, tag_d;
  logic                  valid_q, valid_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [31:2]           addr_q, addr_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  store_q, store_d;
  logic                  resp_q, resp_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic [31:0]           baddr_q, baddr_d;
  logic [BEAT_WIDTH-1:0] bwdata_q, bwdata_d;

  logic req_store, hit, last_beat, merge;
  logic unused_addr_bits;

  assign unused_addr_bits = ^bus.dmem_addr[1:0];
  assign req_store = |bus.dmem_wmask;
  assign hit       = valid_q && (tag_q == bus.dmem_addr[31:OffBits]);
  assign last_beat = (cnt_q == CntW'(LINE_BEATS - 1));

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    store_d = store_q;
    merge   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_store || bus.dmem_rmask) begin
          addr_d  = bus.dmem_addr[31:2];
          wmask_d = bus.dmem_wmask;
          wdata_d = bus.dmem_wdata;
          store_d = req_store;
          if (!hit) begin
            state_d = StFillReq;
          end else if (req_store) begin
            merge   = 1'b1;
            state_d = StWb;
          end else begin
            state_d = StResp;
          end
        end
      end
      StFillReq: begin
        if (bus.bmem_ready) state_d = StFillWait;
      end
      StFillWait: begin
        if (bus.bmem_rvalid) begin
          line_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = bus.bmem_rdata;
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            cnt_d   = '0;
            tag_d   = addr_q[31:OffBits];
            valid_d = 1'b1;
            merge   = store_q;
            state_d = store_q ? StWb : StResp;
          end
        end
      end
      StWb: begin
        if (bus.bmem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = StResp;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Store bytes overlay the freshly filled (or hit) line so the buffer stays coherent.
    if (merge) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_d[i]) begin
          line_d[32*addr_d[OffBits-1:2] + 8*i +: 8] = wdata_d[8*i +: 8];
        end
      end
    end

    resp_d   = (state_d == StResp);
    read_d   = (state_d == StFillReq);
    write_d  = (state_d == StWb);
    baddr_d  = (read_d || write_d) ? {addr_d[31:OffBits], {OffBits{1'b0}}} : '0;
    bwdata_d = write_d ? line_d[cnt_d*BEAT_WIDTH +: BEAT_WIDTH] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      line_q   <= '0;
      tag_q    <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wmask_q  <= '0;
      wdata_q  <= '0;
      store_q  <= 1'b0;
      resp_q   <= 1'b0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      baddr_q  <= '0;
      bwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      tag_q    <= tag_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wmask_q  <= wmask_d;
      wdata_q  <= wdata_d;
      store_q  <= store_d;
      resp_q   <= resp_d;
      read_q   <= read_d;
      write_q  <= write_d;
      baddr_q  <= baddr_d;
      bwdata_q <= bwdata_d;
    end
  end

  assign bus.dmem_resp  = resp_q;
  assign bus.bmem_read  = read_q;
  assign bus.bmem_write = write_q;
  assign bus.bmem_addr  = baddr_q;
  assign bus.bmem_wdata = bwdata_q;
  // Word select straight from the buffer; zero outside a read response.
  assign bus.dmem_rdata = (resp_q && !store_q) ? line_q[32*addr_q[OffBits-1:2] +: 32] : '0;
endmodule
